// File: rtl/yuv_pkg.sv
// Shared constants, word layout and YUV bundle type
// for the RGB333 to packed 4:2:2 YUV encoder.
package yuv_pkg;

    localparam logic signed [17:0] C_YR  =  18'sd66;
    localparam logic signed [17:0] C_YG  =  18'sd129;
    localparam logic signed [17:0] C_YB  =  18'sd25;
    localparam logic signed [17:0] C_UR  = -18'sd38;
    localparam logic signed [17:0] C_UG  = -18'sd74;
    localparam logic signed [17:0] C_UB  =  18'sd112;
    localparam logic signed [17:0] C_VR  =  18'sd112;
    localparam logic signed [17:0] C_VG  = -18'sd94;
    localparam logic signed [17:0] C_VB  = -18'sd18;

    localparam logic signed [17:0] RND   =  18'sd128;
    localparam logic signed [17:0] OFF_Y =  18'sd16;
    localparam logic signed [17:0] OFF_C =  18'sd128;

    localparam int V_MSB  = 31;
    localparam int Y0_MSB = 23;
    localparam int U_MSB  = 15;
    localparam int Y1_MSB = 7;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } yuv_t;

    // Saturate to 0..255, or keep the raw low byte when clamping is off.
    function automatic logic [7:0] sat8(
        input logic signed [17:0] x,
        input logic               clamp
    );
        logic [7:0] r;
        r = x[7:0];
        if (clamp) begin
            if (x < 18'sd0)
                r = 8'd0;
            else if (x > 18'sd255)
                r = 8'd255;
        end
        return r;
    endfunction

endpackage

// File: rtl/rgb2yuv_pixel.sv
// Per-pixel colour conversion pipeline: expand,
// multiply-accumulate, shift, offset and clamp.
module rgb2yuv_pixel
    import yuv_pkg::*;
#(
    parameter int CHAN_W   = 3,
    parameter bit CLAMP_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [3*CHAN_W-1:0]   pix,
    input  logic                  in_eol,
    output logic                  out_valid,
    output logic                  out_eol,
    output yuv_t                  out_yuv
);

    logic [CHAN_W-1:0] r_c, g_c, b_c;
    logic [7:0]        r_x, g_x, b_x;
    logic [7:0]        r8, g8, b8;
    logic              v0, e0;

    logic signed [17:0] rs, gs, bs;
    logic signed [17:0] sum_y, sum_u, sum_v;
    logic signed [17:0] sy, su, sv;
    logic               v1, e1;

    logic signed [17:0] off_y, off_u, off_v;

    assign r_c = pix[3*CHAN_W-1:2*CHAN_W];
    assign g_c = pix[2*CHAN_W-1:CHAN_W];
    assign b_c = pix[CHAN_W-1:0];

    // Replicate each channel MSB-first until it fills 8 bits.
    always_comb begin
        r_x = '0;
        g_x = '0;
        b_x = '0;
        for (int i = 0; i < 8; i++) begin
            r_x[7-i] = r_c[CHAN_W-1-(i%CHAN_W)];
            g_x[7-i] = g_c[CHAN_W-1-(i%CHAN_W)];
            b_x[7-i] = b_c[CHAN_W-1-(i%CHAN_W)];
        end
    end

    // Input register holding the expanded channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r8 <= '0;
            g8 <= '0;
            b8 <= '0;
            v0 <= 1'b0;
            e0 <= 1'b0;
        end else if (en) begin
            r8 <= r_x;
            g8 <= g_x;
            b8 <= b_x;
            v0 <= in_valid;
            e0 <= in_eol & in_valid;
        end
    end

    // Weighted sums including the rounding constant.
    always_comb begin
        rs    = $signed({10'd0, r8});
        gs    = $signed({10'd0, g8});
        bs    = $signed({10'd0, b8});
        sum_y = C_YR * rs + C_YG * gs + C_YB * bs + RND;
        sum_u = C_UR * rs + C_UG * gs + C_UB * bs + RND;
        sum_v = C_VR * rs + C_VG * gs + C_VB * bs + RND;
    end

    // Product stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sy <= '0;
            su <= '0;
            sv <= '0;
            v1 <= 1'b0;
            e1 <= 1'b0;
        end else if (en) begin
            sy <= sum_y;
            su <= sum_u;
            sv <= sum_v;
            v1 <= v0;
            e1 <= e0;
        end
    end

    // Floor-divide by 256 and add the channel offsets.
    always_comb begin
        off_y = (sy >>> 8) + OFF_Y;
        off_u = (su >>> 8) + OFF_C;
        off_v = (sv >>> 8) + OFF_C;
    end

    // Output stage register with optional clamping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_yuv   <= '0;
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
        end else if (en) begin
            out_yuv.y <= sat8(off_y, CLAMP_EN);
            out_yuv.u <= sat8(off_u, CLAMP_EN);
            out_yuv.v <= sat8(off_v, CLAMP_EN);
            out_valid <= v1;
            out_eol   <= e1;
        end
    end

endmodule

// File: rtl/rgb2yuv_packer.sv
// RGB333 stream to packed {V,Y0,U,Y1} 4:2:2 words,
// padding odd-length lines by repeating the last Y.
module rgb2yuv_packer
    import yuv_pkg::*;
#(
    parameter int CHAN_W   = 3,
    parameter bit CLAMP_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [3*CHAN_W-1:0]   s_pix,
    input  logic                  s_eol,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [31:0]           m_yuv,
    output logic                  m_eol,
    output logic [15:0]           pad_cnt
);

    localparam logic PH_EVEN = 1'b0;
    localparam logic PH_ODD  = 1'b1;

    logic        en;
    logic        p_valid;
    logic        p_eol;
    yuv_t        p_yuv;

    logic        phase;
    logic [7:0]  y0, u0, v0;
    logic [8:0]  u_sum, v_sum;
    logic [31:0] word_pair, word_pad;

    assign en      = ~m_valid | m_ready;
    assign s_ready = en;

    rgb2yuv_pixel #(
        .CHAN_W   (CHAN_W),
        .CLAMP_EN (CLAMP_EN)
    ) u_pixel (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (s_valid),
        .pix       (s_pix),
        .in_eol    (s_eol),
        .out_valid (p_valid),
        .out_eol   (p_eol),
        .out_yuv   (p_yuv)
    );

    // Chroma averages and the two candidate output words.
    always_comb begin
        u_sum     = {1'b0, u0} + {1'b0, p_yuv.u} + 9'd1;
        v_sum     = {1'b0, v0} + {1'b0, p_yuv.v} + 9'd1;
        word_pair = '0;
        word_pair[V_MSB  -: 8] = v_sum[8:1];
        word_pair[Y0_MSB -: 8] = y0;
        word_pair[U_MSB  -: 8] = u_sum[8:1];
        word_pair[Y1_MSB -: 8] = p_yuv.y;
        word_pad  = '0;
        word_pad[V_MSB  -: 8]  = p_yuv.v;
        word_pad[Y0_MSB -: 8]  = p_yuv.y;
        word_pad[U_MSB  -: 8]  = p_yuv.u;
        word_pad[Y1_MSB -: 8]  = p_yuv.y;
    end

    // Pair FSM, output word register and pad counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= PH_EVEN;
            y0      <= '0;
            u0      <= '0;
            v0      <= '0;
            m_valid <= 1'b0;
            m_yuv   <= '0;
            m_eol   <= 1'b0;
            pad_cnt <= '0;
        end else if (en) begin
            m_valid <= 1'b0;
            if (p_valid) begin
                unique case (phase)
                    PH_EVEN: begin
                        if (p_eol) begin
                            m_valid <= 1'b1;
                            m_yuv   <= word_pad;
                            m_eol   <= 1'b1;
                            if (pad_cnt != 16'hFFFF)
                                pad_cnt <= pad_cnt + 16'd1;
                        end else begin
                            y0    <= p_yuv.y;
                            u0    <= p_yuv.u;
                            v0    <= p_yuv.v;
                            phase <= PH_ODD;
                        end
                    end
                    PH_ODD: begin
                        m_valid <= 1'b1;
                        m_yuv   <= word_pair;
                        m_eol   <= p_eol;
                        phase   <= PH_EVEN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgb2yuv_packer.sv
// Directed-vector bench for rgb2yuv_packer with
// hand-computed YUV words and a handshake monitor.
module tb_rgb2yuv_packer;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [8:0]  s_pix;
    logic        s_eol;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_yuv;
    logic        m_eol;
    logic [15:0] pad_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] q[$];

    rgb2yuv_packer #(
        .CHAN_W   (3),
        .CLAMP_EN (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_pix   (s_pix),
        .s_eol   (s_eol),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_yuv   (m_yuv),
        .m_eol   (m_eol),
        .pad_cnt (pad_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every completed output handshake.
    always @(posedge clk) begin
        if (rst_n && m_valid && m_ready)
            q.push_back({m_eol, m_yuv});
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic push(input logic [8:0] pix, input logic eol);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_pix   = pix;
        s_eol   = eol;
        forever begin
            @(posedge clk);
            if (s_ready) break;
            n++;
            if (n >= 200) begin
                check("push_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic get_word(input string tag,
                            input logic [31:0] exp_yuv,
                            input logic exp_eol);
        int n;
        logic [32:0] w;
        n = 0;
        while (q.size() == 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            w = q.pop_front();
            check(tag, w[31:0], exp_yuv);
            check({tag, "_eol"}, {31'd0, w[32]}, {31'd0, exp_eol});
        end
    endtask

    initial begin
        logic [31:0] held;
        int n;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_pix   = '0;
        s_eol   = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_yuv", m_yuv, 32'd0);
        check("rst_m_eol", {31'd0, m_eol}, 32'd0);
        check("rst_pad_cnt", {16'd0, pad_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);

        // White pair with latency check.
        m_ready = 1'b1;
        push(9'h1FF, 1'b0);
        push(9'h1FF, 1'b0);
        check("lat_t0", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        check("lat_t1", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        check("lat_t2", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        check("lat_t3", {31'd0, m_valid}, 32'd1);
        check("lat_word", m_yuv, 32'h80EB80EB);
        get_word("white", 32'h80EB80EB, 1'b0);

        // Red then blue, two reds, two blacks.
        push(9'h1C0, 1'b0);
        push(9'h007, 1'b0);
        get_word("red_blue", 32'hAF52A529, 1'b0);
        push(9'h1C0, 1'b0);
        push(9'h1C0, 1'b0);
        get_word("red_red", 32'hF0525A52, 1'b0);
        push(9'h000, 1'b0);
        push(9'h000, 1'b0);
        get_word("black", 32'h80108010, 1'b0);

        // Odd-length line gets padded.
        push(9'h000, 1'b0);
        push(9'h000, 1'b0);
        push(9'h000, 1'b1);
        get_word("odd_w0", 32'h80108010, 1'b0);
        get_word("odd_w1", 32'h80108010, 1'b1);
        check("pad_cnt1", {16'd0, pad_cnt}, 32'd1);

        // Backpressure during an 8-pixel stream.
        repeat (4) @(negedge clk);
        q.delete();
        fork
            begin
                for (int i = 0; i < 8; i++)
                    push(9'h1FF, 1'b0);
            end
            begin
                n = 0;
                while (!m_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_first", {31'd0, m_valid}, 32'd1);
                m_ready = 1'b0;
                held = m_yuv;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("bp_s_ready", {31'd0, s_ready}, 32'd0);
                    check("bp_hold", m_yuv, held);
                    check("bp_valid", {31'd0, m_valid}, 32'd1);
                end
                m_ready = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        check("bp_count", q.size(), 32'd4);
        for (int k = 0; k < 4; k++)
            get_word("bp_word", 32'h80EB80EB, 1'b0);

        // Reset while a word is held and a pair is half-built.
        m_ready = 1'b0;
        push(9'h1FF, 1'b0);
        push(9'h1FF, 1'b0);
        push(9'h1C0, 1'b0);
        repeat (6) @(negedge clk);
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, m_valid}, 32'd0);
        check("arst_pad", {16'd0, pad_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_ready = 1'b1;
        @(negedge clk);
        push(9'h000, 1'b0);
        push(9'h000, 1'b0);
        get_word("post_rst", 32'h80108010, 1'b0);
        repeat (10) @(negedge clk);
        check("post_rst_cnt", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
